mac_seq_divider: RTL

- Sequential restoring divider that undoes the MAC datapath: divides a 10-bit accumulated value by a 4-bit operand, giving a 10-bit quotient and a 4-bit remainder.
- Produces one quotient bit per step, MSB first, under a start/busy/done handshake.
- Steps are paced by an internal clock-enable tick derived from clkin, so the block runs at the same slow rate as the accumulator. No derived clock is used.

---
 rtl/mac_seq_divider.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mac_seq_divider.sv
// rtl/mac_seq_divider.sv - tick-paced restoring divider, 10-bit dividend by 4-bit divisor
module mac_seq_divider #(
    parameter int DIV = 4999
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [9:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    localparam int TW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [TW-1:0] DIV_T = TW'(DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    step_cnt;
    logic          last_step;
    logic [4:0]    pr;
    logic [4:0]    pr_shift;
    logic [4:0]    pr_next;
    logic          q_bit;
    logic [9:0]    dvd_sr;
    logic [3:0]    dvs_r;
    logic [9:0]    q_sr;

    assign tick      = (tick_cnt == DIV_T);
    assign last_step = tick && (step_cnt == 4'd9);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        pr_shift = {pr[3:0], dvd_sr[9]};
        q_bit    = (pr_shift >= {1'b0, dvs_r});
        pr_next  = pr_shift;
        if (q_bit) begin
            pr_next = pr_shift - {1'b0, dvs_r};
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            tick_cnt    <= '0;
            step_cnt    <= 4'd0;
            pr          <= 5'd0;
            dvd_sr      <= 10'd0;
            dvs_r       <= 4'd0;
            q_sr        <= 10'd0;
            quotient    <= 10'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_sr   <= dividend;
                        dvs_r    <= divisor;
                        tick_cnt <= '0;
                        step_cnt <= 4'd0;
                        pr       <= 5'd0;
                        q_sr     <= 10'd0;
                        // Zero divisor skips the iteration and reports saturated quotient.
                        if (divisor == 4'd0) begin
                            quotient    <= 10'h3FF;
                            remainder   <= 4'd0;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        pr       <= pr_next;
                        dvd_sr   <= {dvd_sr[8:0], 1'b0};
                        q_sr     <= {q_sr[8:0], q_bit};
                        step_cnt <= step_cnt + 4'd1;
                        if (step_cnt == 4'd9) begin
                            quotient    <= {q_sr[8:0], q_bit};
                            remainder   <= pr_next[3:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
